// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Time-slot arbiter sharing one single-port, 1-cycle-latency video
//            RAM between display scan-out fetches and a CPU req/ack port.
//            Also emits a registered frame_start pulse at vertical blanking.
// Revision : 1.0  initial release
// ============================================================================
module vram_arbiter #(
   parameter int HORIZ_PIXELS = 640,
   parameter int VERT_PIXELS  = 480,
   parameter int VCNT_MAX     = 524,
   parameter int PREFETCH_COL = 784,
   parameter int WORD_BITS    = 16,
   parameter int ADDR_W       = 15
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic [11:0]          pixel_row,
   input  logic [11:0]          pixel_column,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [ADDR_W-1:0]    cpu_addr,
   input  logic [WORD_BITS-1:0] cpu_wdata,
   output logic                 cpu_ack,
   output logic [WORD_BITS-1:0] cpu_rdata,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [WORD_BITS-1:0] mem_wdata,
   input  logic [WORD_BITS-1:0] mem_rdata,
   output logic [WORD_BITS-1:0] vid_data,
   output logic                 vid_valid,
   output logic                 frame_start
);

   localparam int          WORD_SHIFT        = $clog2(WORD_BITS);
   localparam logic [31:0] C_WORDS_PER_ROW   = 32'(HORIZ_PIXELS / WORD_BITS);
   localparam logic [11:0] C_WORD_MASK       = 12'(WORD_BITS - 1);
   localparam logic [11:0] C_LAST_SLOT_LIMIT = 12'(HORIZ_PIXELS - WORD_BITS);
   localparam logic [11:0] C_PREFETCH_COL    = 12'(PREFETCH_COL);
   localparam logic [11:0] C_VCNT_MAX        = 12'(VCNT_MAX);
   localparam logic [11:0] C_VERT_PIXELS     = 12'(VERT_PIXELS);

   typedef enum logic [1:0] {
      CPU_IDLE = 2'd0,
      CPU_BUSY = 2'd1,
      CPU_ACK  = 2'd2
   } cpu_state_t;

   // Slot decode and address generation
   logic                 slot;
   logic                 vid_fetch;
   logic [11:0]          target_row;
   logic [11:0]          word_idx;
   logic [ADDR_W-1:0]    row_ext;
   logic [ADDR_W-1:0]    vid_addr;
   logic                 cpu_grant;

   // Register state (_q) and next values (_d)
   cpu_state_t           state_q,       state_d;
   logic                 mem_en_q,      mem_en_d;
   logic                 mem_we_q,      mem_we_d;
   logic [ADDR_W-1:0]    mem_addr_q,    mem_addr_d;
   logic [WORD_BITS-1:0] mem_wdata_q,   mem_wdata_d;
   logic                 tag1_vid_q,    tag1_vid_d;
   logic                 tag1_cpu_q,    tag1_cpu_d;
   logic                 tag2_vid_q,    tag2_vid_d;
   logic                 tag2_cpu_q,    tag2_cpu_d;
   logic                 vid_valid_q,   vid_valid_d;
   logic [WORD_BITS-1:0] vid_data_q,    vid_data_d;
   logic                 cpu_ack_q,     cpu_ack_d;
   logic [WORD_BITS-1:0] cpu_rdata_q,   cpu_rdata_d;
   logic                 frame_start_q, frame_start_d;

   // Decide whether this column is a display slot and which row/word it targets
   always_comb begin
      slot       = 1'b0;
      target_row = 12'd0;
      word_idx   = 12'd0;
      if (((pixel_column & C_WORD_MASK) == 12'd0) && (pixel_column < C_LAST_SLOT_LIMIT)) begin
         // In-line fetch: one word ahead of the word currently being shifted out
         slot       = 1'b1;
         target_row = pixel_row;
         word_idx   = (pixel_column >> WORD_SHIFT) + 12'd1;
      end else if (pixel_column == C_PREFETCH_COL) begin
         // Horizontal blanking: word 0 of the next row, wrapping at the last row
         slot       = 1'b1;
         target_row = (pixel_row == C_VCNT_MAX) ? 12'd0 : pixel_row + 12'd1;
         word_idx   = 12'd0;
      end
      // Rows in vertical blanking have nothing to display, so the slot stays free
      vid_fetch = slot && (target_row < C_VERT_PIXELS);
   end

   // Word address = target_row * words_per_row + word, built as a shift-add chain
   always_comb begin
      row_ext  = ADDR_W'(target_row);
      vid_addr = '0;
      for (int i = 0; i < ADDR_W; i++) begin
         if (C_WORDS_PER_ROW[i]) begin
            vid_addr = vid_addr + (row_ext << i);
         end
      end
      vid_addr = vid_addr + ADDR_W'(word_idx);
   end

   // Next-state logic for the grant, the tagged read pipeline, CPU FSM and frame pulse
   always_comb begin
      cpu_grant   = cpu_req && (state_q == CPU_IDLE) && !vid_fetch;

      mem_en_d    = vid_fetch || cpu_grant;
      mem_we_d    = cpu_grant && cpu_we;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      if (vid_fetch) begin
         mem_addr_d = vid_addr;
      end else if (cpu_grant) begin
         mem_addr_d = cpu_addr;
         if (cpu_we) begin
            mem_wdata_d = cpu_wdata;
         end
      end

      // Owner tags travel alongside the access so returning data is steered correctly
      tag1_vid_d  = vid_fetch;
      tag1_cpu_d  = cpu_grant;
      tag2_vid_d  = tag1_vid_q;
      tag2_cpu_d  = tag1_cpu_q;

      vid_valid_d = tag2_vid_q;
      vid_data_d  = tag2_vid_q ? mem_rdata : vid_data_q;
      cpu_ack_d   = tag2_cpu_q;
      cpu_rdata_d = tag2_cpu_q ? mem_rdata : cpu_rdata_q;

      frame_start_d = (pixel_row == C_VERT_PIXELS) && (pixel_column == 12'd0);

      state_d = state_q;
      case (state_q)
         CPU_IDLE: if (cpu_grant)  state_d = CPU_BUSY;
         CPU_BUSY: if (tag2_cpu_q) state_d = CPU_ACK;
         CPU_ACK:                  state_d = CPU_IDLE;
         default:                  state_d = CPU_IDLE;
      endcase
   end

   // All state registers; reset abandons any in-flight access without an ack
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q       <= CPU_IDLE;
         mem_en_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         tag1_vid_q    <= 1'b0;
         tag1_cpu_q    <= 1'b0;
         tag2_vid_q    <= 1'b0;
         tag2_cpu_q    <= 1'b0;
         vid_valid_q   <= 1'b0;
         vid_data_q    <= '0;
         cpu_ack_q     <= 1'b0;
         cpu_rdata_q   <= '0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_en_q      <= mem_en_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         tag1_vid_q    <= tag1_vid_d;
         tag1_cpu_q    <= tag1_cpu_d;
         tag2_vid_q    <= tag2_vid_d;
         tag2_cpu_q    <= tag2_cpu_d;
         vid_valid_q   <= vid_valid_d;
         vid_data_q    <= vid_data_d;
         cpu_ack_q     <= cpu_ack_d;
         cpu_rdata_q   <= cpu_rdata_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign cpu_ack     = cpu_ack_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign mem_en      = mem_en_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign vid_data    = vid_data_q;
   assign vid_valid   = vid_valid_q;
   assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Scoreboard bench for vram_arbiter with a behavioural VRAM model.
//            Stimulus pushes expected accesses/responses; monitors pop them.
// Revision : 1.0  initial release
// ============================================================================
module tb_vram_arbiter;

   localparam int ADDR_W = 15;
   localparam int WB     = 16;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic              rst          = 1'b1;
   logic [11:0]       pixel_row    = '0;
   logic [11:0]       pixel_column = '0;
   logic              cpu_req      = 1'b0;
   logic              cpu_we       = 1'b0;
   logic [ADDR_W-1:0] cpu_addr     = '0;
   logic [WB-1:0]     cpu_wdata    = '0;
   logic              cpu_ack;
   logic [WB-1:0]     cpu_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WB-1:0]     mem_wdata;
   logic [WB-1:0]     mem_rdata    = '0;
   logic [WB-1:0]     vid_data;
   logic              vid_valid;
   logic              frame_start;

   vram_arbiter dut (
      .clock        (clock),
      .rst          (rst),
      .pixel_row    (pixel_row),
      .pixel_column (pixel_column),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_ack      (cpu_ack),
      .cpu_rdata    (cpu_rdata),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .vid_data     (vid_data),
      .vid_valid    (vid_valid),
      .frame_start  (frame_start)
   );

   // Background content of never-written VRAM words
   function automatic logic [WB-1:0] pat(input logic [ADDR_W-1:0] a);
      return {1'b1, a} ^ 16'h5A5A;
   endfunction

   // VRAM model: single port, read data one cycle after mem_en
   logic [WB-1:0] mem_store   [0:32767];
   bit            mem_written [0:32767];
   always @(posedge clock) begin
      if (mem_en === 1'b1) begin
         if (mem_we === 1'b1) begin
            mem_store[mem_addr]   <= mem_wdata;
            mem_written[mem_addr] <= 1'b1;
         end else begin
            mem_rdata <= mem_written[mem_addr] ? mem_store[mem_addr] : pat(mem_addr);
         end
      end
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard queues
   typedef struct packed {
      int                cyc;
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [WB-1:0]     wdata;
   } mem_exp_t;
   typedef struct packed {
      int            cyc;
      logic          chk;
      logic [WB-1:0] data;
   } dat_exp_t;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [WB-1:0]     wdata;
   } cpu_op_t;

   mem_exp_t mem_q[$];
   dat_exp_t vid_q[$];
   dat_exp_t cpu_q[$];
   int       fs_q[$];
   cpu_op_t  cpu_ops[$];

   task automatic push_mem(input int t, input logic [ADDR_W-1:0] a, input logic w,
                           input logic [WB-1:0] d);
      mem_exp_t e;
      int i;
      e.cyc = t; e.addr = a; e.we = w; e.wdata = d;
      i = 0;
      while (i < mem_q.size() && mem_q[i].cyc <= t) i++;
      mem_q.insert(i, e);
   endtask

   task automatic push_cpu(input int t, input logic c, input logic [WB-1:0] d);
      dat_exp_t e;
      e.cyc = t; e.chk = c; e.data = d;
      cpu_q.push_back(e);
   endtask

   // Display fetch decided at cycle t: access at t+1, word delivered at t+3
   task automatic exp_fetch(input int t, input logic [ADDR_W-1:0] a);
      dat_exp_t e;
      push_mem(t + 1, a, 1'b0, '0);
      e.cyc = t + 3; e.chk = 1'b1; e.data = pat(a);
      vid_q.push_back(e);
   endtask

   // Monitors: compare whatever the DUT presents against the queue heads
   logic     ack_flag = 1'b0;
   mem_exp_t mon_m;
   dat_exp_t mon_d;
   int       mon_f;
   always @(negedge clock) begin
      ack_flag = (cpu_ack === 1'b1);

      while (mem_q.size() > 0 && mem_q[0].cyc < cyc) begin
         mon_m = mem_q.pop_front();
         checks++; errors++;
         $display("FAIL mem_missing: no access seen, expected addr %0h at cycle %0d", mon_m.addr, mon_m.cyc);
      end
      if (mem_en === 1'b1) begin
         if (mem_q.size() == 0 || mem_q[0].cyc != cyc) begin
            checks++; errors++;
            $display("FAIL mem_unexpected: got access addr %0h we %0b at cycle %0d, expected none", mem_addr, mem_we, cyc);
         end else begin
            mon_m = mem_q.pop_front();
            chk("mem_addr",  32'(mem_addr),  32'(mon_m.addr));
            chk("mem_we",    32'(mem_we),    32'(mon_m.we));
            chk("mem_wdata", 32'(mem_wdata), 32'(mon_m.wdata));
         end
      end

      while (vid_q.size() > 0 && vid_q[0].cyc < cyc) begin
         mon_d = vid_q.pop_front();
         checks++; errors++;
         $display("FAIL vid_missing: no vid_valid, expected data %0h at cycle %0d", mon_d.data, mon_d.cyc);
      end
      if (vid_valid === 1'b1) begin
         if (vid_q.size() == 0 || vid_q[0].cyc != cyc) begin
            checks++; errors++;
            $display("FAIL vid_unexpected: got vid_valid data %0h at cycle %0d, expected none", vid_data, cyc);
         end else begin
            mon_d = vid_q.pop_front();
            chk("vid_data", 32'(vid_data), 32'(mon_d.data));
         end
      end

      while (cpu_q.size() > 0 && cpu_q[0].cyc < cyc) begin
         mon_d = cpu_q.pop_front();
         checks++; errors++;
         $display("FAIL cpu_ack_missing: no ack, expected at cycle %0d", mon_d.cyc);
      end
      if (cpu_ack === 1'b1) begin
         if (cpu_q.size() == 0 || cpu_q[0].cyc != cyc) begin
            checks++; errors++;
            $display("FAIL cpu_ack_unexpected: got ack at cycle %0d, expected none", cyc);
         end else begin
            mon_d = cpu_q.pop_front();
            if (mon_d.chk) chk("cpu_rdata", 32'(cpu_rdata), 32'(mon_d.data));
         end
      end

      while (fs_q.size() > 0 && fs_q[0] < cyc) begin
         mon_f = fs_q.pop_front();
         checks++; errors++;
         $display("FAIL frame_start_missing: no pulse, expected at cycle %0d", mon_f);
      end
      if (frame_start === 1'b1) begin
         if (fs_q.size() == 0 || fs_q[0] != cyc) begin
            checks++; errors++;
            $display("FAIL frame_start_unexpected: got pulse at cycle %0d, expected none", cyc);
         end else begin
            mon_f = fs_q.pop_front();
            checks++;
         end
      end
   end

   // One pixel-clock step; also plays the CPU master (hold req until ack)
   int      now;
   cpu_op_t op_done;
   task automatic load_op();
      cpu_addr  = cpu_ops[0].addr;
      cpu_we    = cpu_ops[0].we;
      cpu_wdata = cpu_ops[0].wdata;
   endtask

   task automatic tick(input int row, input int col, input logic r);
      @(posedge clock);
      #1;
      if (cpu_req && ack_flag) begin
         op_done = cpu_ops.pop_front();
         if (cpu_ops.size() > 0) load_op();
         else cpu_req = 1'b0;
      end else if (!cpu_req && cpu_ops.size() > 0) begin
         load_op();
         cpu_req = 1'b1;
      end
      rst          = r;
      pixel_row    = 12'(row);
      pixel_column = 12'(col);
      now          = cyc;
   endtask

   task automatic chk_outputs_zero();
      chk("rst_cpu_ack",     32'(cpu_ack),     32'd0);
      chk("rst_cpu_rdata",   32'(cpu_rdata),   32'd0);
      chk("rst_mem_en",      32'(mem_en),      32'd0);
      chk("rst_mem_we",      32'(mem_we),      32'd0);
      chk("rst_mem_addr",    32'(mem_addr),    32'd0);
      chk("rst_mem_wdata",   32'(mem_wdata),   32'd0);
      chk("rst_vid_data",    32'(vid_data),    32'd0);
      chk("rst_vid_valid",   32'(vid_valid),   32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
   endtask

   int base;
   initial begin
      // Power-up reset, three cycles, somewhere mid-frame
      for (int i = 0; i < 3; i++) tick(200, 300 + i, 1'b1);
      @(negedge clock);
      chk_outputs_zero();

      // Row 5: in-line fetches of words 1..39, then word 0 of row 6 at the prefetch column
      for (int c = 0; c < 800; c++) begin
         tick(5, c, 1'b0);
         if ((c % 16) == 0 && c <= 608) exp_fetch(now, 15'(201 + c / 16));
         if (c == 784) exp_fetch(now, 15'd240);
      end

      // Row 7: CPU write at a slot column, read-back, then back-to-back held reads
      for (int c = 0; c < 64; c++) begin
         if (c == 16) cpu_ops.push_back({15'h1234, 1'b1, 16'hBEEF});
         if (c == 24) cpu_ops.push_back({15'h1234, 1'b0, 16'h0000});
         if (c == 40) begin
            for (int k = 0; k < 4; k++) cpu_ops.push_back({15'(16'h0100 + k), 1'b0, 16'h0000});
         end
         tick(7, c, 1'b0);
         if (c == 0) begin
            base = now;
            push_mem(base + 18, 15'h1234, 1'b1, 16'hBEEF);
            push_cpu(base + 20, 1'b0, 16'h0000);
            push_mem(base + 25, 15'h1234, 1'b0, 16'h0000);
            push_cpu(base + 27, 1'b1, 16'hBEEF);
            push_mem(base + 41, 15'h0100, 1'b0, 16'h0000);
            push_cpu(base + 43, 1'b1, pat(15'h0100));
            push_mem(base + 45, 15'h0101, 1'b0, 16'h0000);
            push_cpu(base + 47, 1'b1, pat(15'h0101));
            push_mem(base + 50, 15'h0102, 1'b0, 16'h0000);
            push_cpu(base + 52, 1'b1, pat(15'h0102));
            push_mem(base + 54, 15'h0103, 1'b0, 16'h0000);
            push_cpu(base + 56, 1'b1, pat(15'h0103));
         end
         if ((c % 16) == 0) exp_fetch(now, 15'(281 + c / 16));
      end

      // Reset mid-access: the fetch at col 0 reaches the RAM but is never delivered
      tick(10, 0, 1'b0);
      push_mem(now + 1, 15'd401, 1'b0, '0);
      for (int c = 1; c < 4; c++) tick(10, c, 1'b1);
      @(negedge clock);
      chk_outputs_zero();
      for (int c = 4; c < 21; c++) begin
         tick(10, c, 1'b0);
         if (c == 16) exp_fetch(now, 15'd402);
      end

      // Last active row, then no prefetch for row 480
      for (int c = 0; c < 21; c++) begin
         tick(479, c, 1'b0);
         if (c == 0)  exp_fetch(now, 15'd19161);
         if (c == 16) exp_fetch(now, 15'd19162);
      end
      for (int c = 770; c < 800; c++) tick(479, c, 1'b0);

      // Last row of the frame: nothing in-line, prefetch wraps to row 0 word 0
      for (int c = 0; c < 21; c++) tick(524, c, 1'b0);
      for (int c = 770; c < 800; c++) begin
         tick(524, c, 1'b0);
         if (c == 784) exp_fetch(now, 15'd0);
      end

      // Frame boundary: one pulse at row 480 col 0 only
      for (int c = 0; c < 21; c++) begin
         tick(480, c, 1'b0);
         if (c == 0) fs_q.push_back(now + 1);
      end
      for (int c = 0; c < 6; c++) tick(481, c, 1'b0);
      for (int c = 0; c < 21; c++) begin
         tick(0, c, 1'b0);
         if (c == 0)  exp_fetch(now, 15'd1);
         if (c == 16) exp_fetch(now, 15'd2);
      end

      // Drain the pipeline, then anything still queued was never seen
      for (int i = 0; i < 6; i++) tick(500, 700, 1'b0);
      @(negedge clock);
      #1;
      while (mem_q.size() > 0) begin
         mon_m = mem_q.pop_front();
         checks++; errors++;
         $display("FAIL mem_leftover: access addr %0h expected at cycle %0d never seen", mon_m.addr, mon_m.cyc);
      end
      while (vid_q.size() > 0) begin
         mon_d = vid_q.pop_front();
         checks++; errors++;
         $display("FAIL vid_leftover: word %0h expected at cycle %0d never seen", mon_d.data, mon_d.cyc);
      end
      while (cpu_q.size() > 0) begin
         mon_d = cpu_q.pop_front();
         checks++; errors++;
         $display("FAIL cpu_leftover: ack expected at cycle %0d never seen", mon_d.cyc);
      end
      while (fs_q.size() > 0) begin
         mon_f = fs_q.pop_front();
         checks++; errors++;
         $display("FAIL frame_start_leftover: pulse expected at cycle %0d never seen", mon_f);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
